// File: rtl/recip_norm_ctrl_if.sv
// rtl/recip_norm_ctrl_if.sv - handshake and reciprocal-unit signal bundle for recip_norm_ctrl
interface recip_norm_ctrl_if #(
  parameter int DATA_W  = 10,
  parameter int RECIP_W = 18
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                recip_enb;
  logic [DATA_W-1:0]   recip_x;
  logic [RECIP_W-1:0]  recip_y;
  logic                out_valid;
  logic                out_ready;
  logic [17:0]         out_data;
  logic                row_done;

  // Block side: consumes elements and reciprocal, produces normalized outputs
  modport slave (
    input  in_valid, in_data, recip_y, out_ready,
    output in_ready, recip_enb, recip_x, out_valid, out_data, row_done
  );

  // Environment side: producer, reciprocal unit and consumer
  modport master (
    output in_valid, in_data, recip_y, out_ready,
    input  in_ready, recip_enb, recip_x, out_valid, out_data, row_done
  );
endinterface

// File: rtl/recip_norm_ctrl.sv
// rtl/recip_norm_ctrl.sv - softmax row normalizer: accumulate, one reciprocal lookup, scaled emit
module recip_norm_ctrl #(
  parameter int ROW_LEN = 8,
  parameter int DATA_W  = 10,
  parameter int RECIP_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  recip_norm_ctrl_if.slave  bus
);
  localparam int IDX_W  = $clog2(ROW_LEN);
  localparam int PROD_W = DATA_W + RECIP_W;
  localparam logic [DATA_W-1:0] SUM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(ROW_LEN - 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_RECIP, ST_EMIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   sum_q;
  logic [RECIP_W-1:0]  recip_q;
  logic                out_valid_q;
  logic [17:0]         out_data_q;
  logic [DATA_W-1:0]   buf_q [ROW_LEN];

  logic                in_ready;
  logic                recip_enb;
  logic [DATA_W-1:0]   recip_x;
  logic                row_done;

  logic                in_xfer;
  logic                out_xfer;
  logic [DATA_W-1:0]   elem;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W-1:0]   sum_sat;
  logic [RECIP_W-1:0]  recip_in;
  logic [IDX_W-1:0]    idx_nxt;

  // Unsigned 10.0 x 2.16 product, clamped to the 18-bit 2.16 output range
  function automatic logic [17:0] sat_mul(input logic [DATA_W-1:0] a, input logic [RECIP_W-1:0] r);
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(r);
    if (|p[PROD_W-1:18]) sat_mul = 18'h3FFFF;
    else                 sat_mul = p[17:0];
  endfunction

  // Top input bit is treated as zero, so elements are always non-negative
  assign elem     = bus.in_data & SUM_MAX;
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = (state_q == ST_EMIT) && out_valid_q && bus.out_ready;
  assign sum_ext  = {1'b0, sum_q} + {1'b0, elem};
  assign sum_sat  = (sum_ext > {1'b0, SUM_MAX}) ? SUM_MAX : sum_ext[DATA_W-1:0];
  // Reciprocal of a zero sum is undefined; use zero so the row emits zeros
  assign recip_in = (sum_q != '0) ? bus.recip_y : '0;
  assign idx_nxt  = idx_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  // Next-state: row fill, single reciprocal cycle, then drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (in_xfer && idx_q == LAST)  state_d = ST_RECIP;
      ST_RECIP:                                state_d = ST_EMIT;
      ST_EMIT:  if (out_xfer && idx_q == LAST) state_d = ST_ACCUM;
      default:                                 state_d = ST_ACCUM;
    endcase
  end

  // State-decoded outputs; reciprocal unit is only driven during its one cycle
  always_comb begin
    in_ready  = 1'b0;
    recip_enb = 1'b0;
    recip_x   = '0;
    row_done  = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready = 1'b1;
      ST_RECIP: begin
        recip_x   = sum_q;
        recip_enb = (sum_q != '0);
      end
      ST_EMIT:  row_done = out_xfer && (idx_q == LAST);
      default:  ;
    endcase
  end

  // Row buffer has no reset; it is always refilled before being read
  always_ff @(posedge clk) begin
    if (in_xfer) buf_q[idx_q] <= elem;
  end

  // Datapath: sum/index bookkeeping, reciprocal latch and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      sum_q       <= '0;
      recip_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: if (in_xfer) begin
          sum_q <= sum_sat;
          idx_q <= (idx_q == LAST) ? '0 : idx_nxt;
        end
        ST_RECIP: begin
          // First output uses the live reciprocal so it appears without a bubble
          recip_q     <= recip_in;
          out_data_q  <= sat_mul(buf_q[0], recip_in);
          out_valid_q <= 1'b1;
        end
        ST_EMIT: if (out_xfer) begin
          if (idx_q == LAST) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            idx_q       <= '0;
          end else begin
            idx_q      <= idx_nxt;
            out_data_q <= sat_mul(buf_q[idx_nxt], recip_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.recip_enb = recip_enb;
  assign bus.recip_x   = recip_x;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.row_done  = row_done;
endmodule

// File: tb/tb_recip_norm_ctrl.sv
// tb/tb_recip_norm_ctrl.sv - self-checking bench for recip_norm_ctrl
module tb_recip_norm_ctrl;
  localparam int ROW_LEN = 8;
  localparam int DATA_W  = 10;
  localparam int RECIP_W = 18;
  localparam int ELEM_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int OUT_MAX  = (1 << 18) - 1;

  typedef int row_t [ROW_LEN];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  recip_norm_ctrl_if #(.DATA_W(DATA_W), .RECIP_W(RECIP_W)) bus ();

  recip_norm_ctrl #(.ROW_LEN(ROW_LEN), .DATA_W(DATA_W), .RECIP_W(RECIP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Row sum: elements lose their top bit, total clamps at the largest positive value
  function automatic int model_sum(input row_t e);
    longint s = 0;
    foreach (e[k]) s += (e[k] & ELEM_MAX);
    return (s > ELEM_MAX) ? ELEM_MAX : int'(s);
  endfunction

  function automatic int model_out(input int e, input int r);
    longint p;
    p = longint'(e & ELEM_MAX) * longint'(r);
    return (p > OUT_MAX) ? OUT_MAX : int'(p);
  endfunction

  // rmode: 0 full rate, 1 out_ready toggles 1/0, 2 random gaps and stalls
  task automatic run_row(input row_t e, input int ry, input int rmode, input int abort_after);
    int exp_sum;
    int exp_recip;
    int i;
    int cyc;
    logic rdy;
    exp_sum   = model_sum(e);
    exp_recip = (exp_sum == 0) ? 0 : ry;
    bus.recip_y = RECIP_W'(ry);

    i = 0; cyc = 0;
    while (i < ROW_LEN && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (rmode == 2 && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(e[i]);
      end
      #1;
      chk("accum_in_ready",  bus.in_ready,  1);
      chk("accum_out_valid", bus.out_valid, 0);
      chk("accum_recip_enb", bus.recip_enb, 0);
      chk("accum_recip_x",   bus.recip_x,   0);
      chk("accum_row_done",  bus.row_done,  0);
      @(posedge clk);
      if (bus.in_valid) i++;
      cyc++;
    end
    if (i < ROW_LEN) chk("accum_timeout", i, ROW_LEN);

    // Reciprocal cycle with in_valid held high: nothing may be accepted
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'($urandom);
    #1;
    chk("recip_in_ready",  bus.in_ready,  0);
    chk("recip_enb",       bus.recip_enb, (exp_sum != 0));
    chk("recip_x",         bus.recip_x,   exp_sum);
    chk("recip_out_valid", bus.out_valid, 0);

    i = 0; cyc = 0;
    while (i < ROW_LEN && cyc < 400) begin
      @(negedge clk);
      if (abort_after > 0 && i == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_row_done",  bus.row_done,  0);
        chk("rst_recip_enb", bus.recip_enb, 0);
        chk("rst_recip_x",   bus.recip_x,   0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", bus.in_ready, 1);
        chk("rst_release_row_done", bus.row_done, 0);
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      bus.in_valid  = 1'b1;
      bus.in_data   = DATA_W'($urandom);
      #1;
      chk("emit_out_valid", bus.out_valid, 1);
      chk("emit_out_data",  bus.out_data,  model_out(e[i], exp_recip));
      chk("emit_in_ready",  bus.in_ready,  0);
      chk("emit_recip_enb", bus.recip_enb, 0);
      chk("emit_row_done",  bus.row_done,  (rdy && i == ROW_LEN - 1));
      @(posedge clk);
      if (rdy) i++;
      cyc++;
    end
    if (i < ROW_LEN) chk("emit_timeout", i, ROW_LEN);

    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready",  bus.in_ready,  1);
    chk("post_row_done",  bus.row_done,  0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.recip_y   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data",  bus.out_data,  0);
    chk("reset_row_done",  bus.row_done,  0);
    chk("reset_recip_enb", bus.recip_enb, 0);
    chk("reset_recip_x",   bus.recip_x,   0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 1);

    foreach (r[k]) r[k] = 1;
    run_row(r, 8192, 0, 0);

    r = '{1, 2, 3, 4, 5, 6, 7, 12};
    run_row(r, 1638, 1, 0);

    foreach (r[k]) r[k] = 100;
    run_row(r, 65535, 0, 0);

    foreach (r[k]) r[k] = 0;
    run_row(r, 8192, 0, 0);

    foreach (r[k]) r[k] = $urandom_range(0, 60);
    run_row(r, 4000, 1, 3);

    foreach (r[k]) r[k] = 2;
    run_row(r, 4096, 0, 0);

    for (int n = 0; n < 8; n++) begin
      foreach (r[k]) r[k] = (n % 3 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 70);
      run_row(r, $urandom_range(0, (1 << RECIP_W) - 1), 2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/recip_norm_ctrl.md
RECIP_NORM_CTRL -- requirements
Module: recip_norm_ctrl

Interface
REQ-001 SHALL have parameter ROW_LEN, default 8, meaning elements per softmax row (2..64).
REQ-002 SHALL have parameter DATA_W, default 10, meaning input element width, integer format 10.0.
REQ-003 SHALL have parameter RECIP_W, default 18, meaning reciprocal width, format 2.16.
REQ-004 SHALL have port clk, input, 1 bit, meaning single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits, meaning non-negative element; bit DATA_W-1 is ignored and treated as 0.
REQ-009 SHALL have port recip_enb, output, 1 bit, meaning enable to the shared reciprocal unit.
REQ-010 SHALL have port recip_x, output, DATA_W bits, meaning row sum presented to the reciprocal unit.
REQ-011 SHALL have port recip_y, input, RECIP_W bits, meaning combinational reciprocal result (2.16).
REQ-012 SHALL have port out_valid, output, 1 bit, meaning out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out_data.
REQ-014 SHALL have port out_data, output, 18 bits, meaning normalized element in 2.16 format.
REQ-015 SHALL have port row_done, output, 1 bit, meaning one-cycle pulse on acceptance of the last output of a row.

Function
REQ-016 SHALL implement three states: ACCUM, RECIP and EMIT.
REQ-017 SHALL drive in_ready=1 only in ACCUM; an input transfer occurs when in_valid&&in_ready.
REQ-018 SHALL, on each input transfer in ACCUM, store the element in buffer[idx], add it to sum and increment idx.
REQ-019 SHALL saturate sum at 2^(DATA_W-1)-1 (511 for the default DATA_W), with no wrap.
REQ-020 SHALL go from ACCUM to RECIP on the transfer with idx==ROW_LEN-1, and reset idx to 0.
REQ-021 SHALL, in RECIP (exactly one cycle), drive recip_x=sum and recip_enb=1 if sum!=0, and latch recip_y into recip_reg.
REQ-022 SHALL, in RECIP with sum==0, keep recip_enb=0 and set recip_reg=0, because the reciprocal of 0 is undefined.
REQ-023 SHALL drive recip_enb=0 and recip_x=0 in every state other than RECIP.
REQ-024 SHALL go from RECIP to EMIT and register out_data=sat(buffer[0]*recip_reg) with out_valid=1.
REQ-025 SHALL form the product as 10-bit unsigned × 18-bit unsigned = 28 bits (12.16); if product bits [27:18] are nonzero, out_data=18'h3FFFF, otherwise out_data=product[17:0].
REQ-026 SHALL hold out_data and out_valid stable while out_valid&&!out_ready.
REQ-027 SHALL, on an output transfer with idx<ROW_LEN-1, increment idx and register the next element in the following cycle with no bubble.
REQ-028 SHALL, on the output transfer with idx==ROW_LEN-1, pulse row_done, drop out_valid, clear sum and idx, and return to ACCUM.
REQ-029 SHALL give a latency of 2 cycles from the last input transfer to the first out_valid.
REQ-030 SHALL sustain a throughput of ROW_LEN+1+ROW_LEN cycles per row at full handshake rate; input and output of different rows do not overlap.
REQ-031 SHALL ignore in_valid outside ACCUM and out_ready outside EMIT.

Reset
REQ-032 SHALL, on rst_n low and asynchronously at any time including mid-row, enter ACCUM with idx=0, sum=0, recip_reg=0.
REQ-033 SHALL, on rst_n low, clear out_valid, out_data, row_done, recip_enb and recip_x to 0; buffer contents need not be cleared.
REQ-034 SHALL make in_ready=1 in the first cycle after rst_n deasserts.
REQ-035 SHALL discard any partial row or pending output on reset, with no spurious row_done.

Verification
REQ-036 Bench SHALL drive 8 elements of 1, stub recip_y=8192 -> recip_x=8, recip_enb high for one cycle, then 8 outputs of 8192 with row_done on the 8th.
REQ-037 Bench SHALL drive elements 1,2,3,4,5,6,7,12 (sum 40), recip_y=1638, out_ready toggled 1/0 -> outputs 1638,3276,...,19656, each held stable while stalled.
REQ-038 Bench SHALL drive 8 elements of 100 -> sum saturates, recip_x=511; with recip_y=65535, outputs saturate to 18'h3FFFF.
REQ-039 Bench SHALL drive 8 elements of 0 -> recip_enb stays 0, 8 outputs of 0, row_done pulses.
REQ-040 Bench SHALL assert rst_n low after 3 outputs of a row, then feed a fresh row of 2s with recip_y=4096 -> no row_done for the aborted row, new outputs all 8192.
REQ-041 Bench SHALL hold in_valid=1 during RECIP and EMIT -> no input is accepted and sum is unchanged.
